calc_seq_ctrl: RTL and testbench



---
 rtl/calc_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_calc_seq_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: control FSM for the calculator datapath.
// It steps through operand load (WRITE1/WRITE2), register-file read (READ),
// ALU execute (EXEC) and output (OUTPUT). Optional accumulate passes
// (ACC_READ/EXEC pairs) run on the result register. Illegal opcodes go to ERR.
// Ports:
//   clk, rst          clock, async active-high reset
//   go, op, mode, iter start request and run parameters (sampled in IDLE)
//   s1                input mux select (3=in1, 2=in2, 0=ALU result)
//   WA, WE            register-file write address / enable
//   RAA, RAB, REA, REB register-file read addresses / enables
//   C                 ALU control (latched op, EXEC only)
//   S2                output mux select
//   cs                current state code
//   busy, done, err   handshake: busy while not IDLE, done/err one-cycle pulses
module calc_seq_ctrl #(
  parameter int ADDR_W  = 2,
  parameter int OP_W    = 3,
  parameter int NUM_OPS = 4,
  parameter int CNT_W   = 4,
  parameter int A_ADDR  = 1,
  parameter int B_ADDR  = 2,
  parameter int R_ADDR  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [OP_W-1:0]   op,
  input  logic              mode,
  input  logic [CNT_W-1:0]  iter,
  output logic [1:0]        s1,
  output logic [ADDR_W-1:0] WA,
  output logic              WE,
  output logic [ADDR_W-1:0] RAA,
  output logic [ADDR_W-1:0] RAB,
  output logic              REA,
  output logic              REB,
  output logic [OP_W-1:0]   C,
  output logic              S2,
  output logic [2:0]        cs,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WRITE1   = 3'd1,
    S_WRITE2   = 3'd2,
    S_READ     = 3'd3,
    S_EXEC     = 3'd4,
    S_ACC_READ = 3'd5,
    S_OUTPUT   = 3'd6,
    S_ERR      = 3'd7
  } state_e;

  localparam logic [ADDR_W-1:0] A_A = ADDR_W'(A_ADDR);
  localparam logic [ADDR_W-1:0] B_A = ADDR_W'(B_ADDR);
  localparam logic [ADDR_W-1:0] R_A = ADDR_W'(R_ADDR);
  // one extra bit so NUM_OPS = 2^OP_W (no illegal ops) compares correctly
  localparam logic [OP_W:0]     OPS_LIM = (OP_W+1)'(NUM_OPS);

  state_e           state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] rem_q, rem_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      mode_q  <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    unique case (state_q)
      S_IDLE: if (go) begin
        op_d    = op;
        mode_d  = mode;
        rem_d   = mode ? iter : '0;
        state_d = ({1'b0, op} >= OPS_LIM) ? S_ERR : S_WRITE1;
      end
      S_WRITE1:   state_d = S_WRITE2;
      S_WRITE2:   state_d = S_READ;
      S_READ:     state_d = S_EXEC;
      // rem is only loaded non-zero in accumulate mode; guarding on mode_q too
      // keeps a single run from ever chaining passes
      S_EXEC: if (mode_q && rem_q != '0) begin
        rem_d   = rem_q - 1'b1;
        state_d = S_ACC_READ;
      end else begin
        state_d = S_OUTPUT;
      end
      S_ACC_READ: state_d = S_EXEC;
      S_OUTPUT:   state_d = S_IDLE;
      S_ERR:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Moore output decode
  always_comb begin
    s1   = 2'd0;
    WA   = '0;
    WE   = 1'b0;
    RAA  = '0;
    RAB  = '0;
    REA  = 1'b0;
    REB  = 1'b0;
    C    = '0;
    S2   = 1'b0;
    done = 1'b0;
    err  = 1'b0;
    unique case (state_q)
      S_WRITE1:   begin s1 = 2'd3; WA = A_A; WE = 1'b1; end
      S_WRITE2:   begin s1 = 2'd2; WA = B_A; WE = 1'b1; end
      S_READ:     begin RAA = A_A; RAB = B_A; REA = 1'b1; REB = 1'b1; end
      S_EXEC:     begin s1 = 2'd0; WA = R_A; WE = 1'b1; C = op_q; end
      S_ACC_READ: begin RAA = R_A; RAB = B_A; REA = 1'b1; REB = 1'b1; end
      S_OUTPUT:   begin S2 = 1'b1; done = 1'b1; end
      S_ERR:      err = 1'b1;
      default:    ;
    endcase
  end

  assign cs   = state_q;
  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_calc_seq_ctrl.sv
module tb_calc_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       go = 1'b0;
  logic [2:0] op = '0;
  logic       mode = 1'b0;
  logic [3:0] iter = '0;
  logic [1:0] s1, WA, RAA, RAB;
  logic       WE, REA, REB, S2, busy, done, err;
  logic [2:0] C, cs;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  calc_seq_ctrl dut (
    .clk(clk), .rst(rst), .go(go), .op(op), .mode(mode), .iter(iter),
    .s1(s1), .WA(WA), .WE(WE), .RAA(RAA), .RAB(RAB), .REA(REA), .REB(REB),
    .C(C), .S2(S2), .cs(cs), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  wire [20:0] dut_vec = {s1, WA, WE, RAA, RAB, REA, REB, C, S2, cs, busy, done, err};

  // Expected output vector for a state code, straight from the state table.
  function automatic logic [20:0] exp_vec(int st, logic [2:0] opq);
    logic [1:0] e_s1 = 0, e_wa = 0, e_raa = 0, e_rab = 0;
    logic e_we = 0, e_rea = 0, e_reb = 0, e_s2 = 0, e_dn = 0, e_er = 0;
    logic [2:0] e_c = 0;
    case (st)
      1: begin e_s1 = 3; e_wa = 1; e_we = 1; end
      2: begin e_s1 = 2; e_wa = 2; e_we = 1; end
      3: begin e_raa = 1; e_rab = 2; e_rea = 1; e_reb = 1; end
      4: begin e_wa = 3; e_we = 1; e_c = opq; end
      5: begin e_raa = 3; e_rab = 2; e_rea = 1; e_reb = 1; end
      6: begin e_s2 = 1; e_dn = 1; end
      7: e_er = 1;
      default: ;
    endcase
    return {e_s1, e_wa, e_we, e_raa, e_rab, e_rea, e_reb, e_c, e_s2,
            3'(st), (st != 0), e_dn, e_er};
  endfunction

  // Reference model: expected state sequence after the accepting edge,
  // ending with the IDLE cycle.
  function automatic void build_seq(int o, int m, int n);
    if (o >= 4) exp_q.push_back(7);
    else begin
      exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4);
      for (int k = 0; k < (m ? n : 0); k++) begin
        exp_q.push_back(5); exp_q.push_back(4);
      end
      exp_q.push_back(6);
    end
    exp_q.push_back(0);
  endfunction

  // Present go with run parameters, take the accepting edge, then scramble inputs.
  task automatic start(input logic [2:0] o, input logic m, input logic [3:0] n);
    go = 1'b1; op = o; mode = m; iter = n;
    @(posedge clk); #1;
    go = 1'b0; op = 3'($urandom); mode = 1'($urandom); iter = 4'($urandom);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #12;
    checks++;
    if (dut_vec !== exp_vec(0, 0)) begin
      errors++; $display("FAIL reset_state got %h exp %h", dut_vec, exp_vec(0, 0));
    end
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== exp_vec(0, 0)) begin
        errors++; $display("FAIL idle_hold cyc %0d got %h exp %h", i, dut_vec, exp_vec(0, 0));
      end
    end
    // async reset mid-run, mid-cycle
    start(3'd2, 1'b0, 4'd0);
    @(posedge clk); #3; rst = 1'b1; #1;
    checks++;
    if (dut_vec !== exp_vec(0, 0)) begin
      errors++; $display("FAIL async_reset got %h exp %h", dut_vec, exp_vec(0, 0));
    end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic run_check(input string name, input logic [2:0] o, input logic m,
                           input logic [3:0] n);
    exp_q.delete(); build_seq(o, m, n);
    start(o, m, n);
    foreach (exp_q[i]) begin
      checks++;
      if (dut_vec !== exp_vec(exp_q[i], o)) begin
        errors++;
        $display("FAIL %s op=%0d mode=%0d iter=%0d cyc %0d got %h exp %h",
                 name, o, m, n, i + 1, dut_vec, exp_vec(exp_q[i], o));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_single;    run_check("single", 3'd1, 1'b0, 4'd5); endtask
  task automatic test_accum;     run_check("accum", 3'd0, 1'b1, 4'd3);  endtask
  task automatic test_illegal;   run_check("illegal", 3'd5, 1'b1, 4'd2); endtask
  task automatic test_max_iter;  run_check("max_iter", 3'd3, 1'b1, 4'd15); endtask

  task automatic test_latch_busy;
    exp_q.delete(); build_seq(0, 0, 0);
    repeat (3) exp_q.push_back(0);   // no second run may follow
    start(3'd0, 1'b0, 4'd0);
    foreach (exp_q[i]) begin
      if (i == 2) begin op = 3'd2; go = 1'b1; end    // during READ
      else go = 1'b0;
      checks++;
      if (dut_vec !== exp_vec(exp_q[i], 3'd0)) begin
        errors++; $display("FAIL latch_busy cyc %0d got %h exp %h", i + 1, dut_vec,
                           exp_vec(exp_q[i], 3'd0));
      end
      @(posedge clk); #1;
    end
    go = 1'b0;
  endtask

  task automatic test_reset_mid_acc;
    exp_q.delete(); build_seq(1, 1, 5);
    start(3'd1, 1'b1, 4'd5);
    for (int i = 0; i < 7; i++) begin   // up to the 2nd ACC_READ
      checks++;
      if (dut_vec !== exp_vec(exp_q[i], 3'd1)) begin
        errors++; $display("FAIL mid_acc cyc %0d got %h exp %h", i + 1, dut_vec,
                           exp_vec(exp_q[i], 3'd1));
      end
      if (i < 6) begin @(posedge clk); #1; end
    end
    #2; rst = 1'b1; #1;
    checks++;
    if (dut_vec !== exp_vec(0, 0)) begin
      errors++; $display("FAIL mid_acc_reset got %h exp %h", dut_vec, exp_vec(0, 0));
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || cs !== 3'd0) begin
      errors++; $display("FAIL mid_acc_hold got cs=%0d done=%0d exp cs=0 done=0", cs, done);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    run_check("after_reset", 3'd2, 1'b0, 4'd9);
  endtask

  task automatic test_back_to_back;
    exp_q.delete(); build_seq(3, 0, 0); build_seq(3, 0, 0);
    go = 1'b1; op = 3'd3; mode = 1'b0; iter = 4'd7;
    @(posedge clk); #1;
    foreach (exp_q[i]) begin
      if (i >= 6) go = 1'b0;   // second run already accepted at this point
      checks++;
      if (dut_vec !== exp_vec(exp_q[i], 3'd3)) begin
        errors++; $display("FAIL back_to_back cyc %0d got %h exp %h", i + 1, dut_vec,
                           exp_vec(exp_q[i], 3'd3));
      end
      @(posedge clk); #1;
    end
    go = 1'b0;
  endtask

  task automatic test_random;
    for (int r = 0; r < 25; r++)
      run_check("random", 3'($urandom), 1'($urandom), 4'($urandom_range(0, 6)));
  endtask

  initial begin
    test_reset;
    test_single;
    test_accum;
    test_illegal;
    test_max_iter;
    test_latch_busy;
    test_reset_mid_acc;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
